// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO burst-drain block.
//   burst_state_t : drain FSM states (IDLE -> STREAM -> GAP -> IDLE)
//   STATS_W       : width of the optional statistics counters
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } burst_state_t;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer for an AXIS-style valid/ready channel.
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   in_data_i/in_valid_i   upstream payload and valid
//   in_ready_o             upstream ready, driven only from a register
//   out_data_o/out_valid_o downstream payload and valid, fully registered
//   out_ready_i            downstream ready
module axis_skid_reg
  import fifo_burst_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] spare_data_q, spare_data_d;
  logic             spare_valid_q, spare_valid_d;
  logic             in_fire;

  // Ready depends only on the spare slot, so it never follows out_ready_i combinationally.
  assign in_ready_o  = !spare_valid_q;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    spare_data_d  = spare_data_q;
    spare_valid_d = spare_valid_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up this cycle: refill from spare first to keep ordering.
      if (spare_valid_q) begin
        out_data_d    = spare_data_q;
        out_valid_d   = 1'b1;
        spare_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the incoming word in the spare slot.
      spare_data_d  = in_data_i;
      spare_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      spare_data_q  <= '0;
      spare_valid_q <= 1'b0;
    end else begin
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      spare_data_q  <= spare_data_d;
      spare_valid_q <= spare_valid_d;
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains fixed-length bursts from an occupancy-counting AXIS FIFO. Once fifo_count reaches
// burst_len, exactly burst_len words are forwarded with TLAST on the last one.
// Ports:
//   clk, rst                           clock; asynchronous active-low reset
//   enable                             permits new bursts to start
//   burst_len                          words per burst, sampled when a burst starts
//   fifo_count                         FIFO occupancy
//   s_axis_tdata/tvalid/tready         FIFO side
//   m_axis_tdata/tvalid/tlast/tready   burst output
//   busy                               high while streaming or in the post-burst gap
//   bursts_done, underrun_cycles       statistics, only with FIFO_BURST_STATS_EN defined
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
`ifdef FIFO_BURST_STATS_EN
  output logic [STATS_W-1:0] bursts_done,
  output logic [STATS_W-1:0] underrun_cycles,
`endif
  output logic               busy
);

  localparam int unsigned CmpW = (LEN_W > COUNT_W) ? LEN_W : COUNT_W;

  burst_state_t     state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [CmpW-1:0]  len_ext, cnt_ext;
  logic             start;
  logic             skid_in_ready;
  logic             s_fire;
  logic             last_word;

  // Both operands zero-extended to a common width for an unsigned compare.
  assign len_ext   = CmpW'(burst_len);
  assign cnt_ext   = CmpW'(fifo_count);
  assign start     = enable && (burst_len != '0) && (cnt_ext >= len_ext);

  assign s_axis_tready = (state_q == STREAM) && skid_in_ready;
  assign s_fire        = s_axis_tready && s_axis_tvalid;
  assign last_word     = (remaining_q == LEN_W'(1));
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (s_fire) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (last_word) begin
            state_d = GAP;
          end
        end
      end
      // One dead cycle so fifo_count catches up with the words just drained.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  axis_skid_reg #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  ({last_word, s_axis_tdata}),
    .in_valid_i (s_axis_tvalid && (state_q == STREAM)),
    .in_ready_o (skid_in_ready),
    .out_data_o ({m_axis_tlast, m_axis_tdata}),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready)
  );

`ifdef FIFO_BURST_STATS_EN
  logic [STATS_W-1:0] bursts_done_q, underrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bursts_done_q <= '0;
      underrun_q    <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        bursts_done_q <= bursts_done_q + STATS_W'(1);
      end
      if ((state_q == STREAM) && s_axis_tready && !s_axis_tvalid) begin
        underrun_q <= underrun_q + STATS_W'(1);
      end
    end
  end

  assign bursts_done     = bursts_done_q;
  assign underrun_cycles = underrun_q;
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain. Inputs change 1 time unit after the rising edge;
// handshakes are recorded on the falling edge, ahead of the edge that completes them.
`timescale 1ns/1ps
module tb_fifo_burst_drain;

`define CHK(tag, obs, exp) \
  begin \
    n_tests++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] burst_len;
  logic [31:0] fifo_count;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
`ifdef FIFO_BURST_STATS_EN
  logic [31:0] bursts_done;
  logic [31:0] underrun_cycles;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          s_rdy_cnt;
  int          stab_err = 0;
  logic        toggle = 1'b0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;
  logic [16:0] mq[$];
  int          mcyc[$];
  logic [15:0] base;

  always #5 clk = ~clk;

  fifo_burst_drain #(
    .WIDTH  (16),
    .LEN_W  (16),
    .COUNT_W(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .burst_len      (burst_len),
    .fifo_count     (fifo_count),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
`ifdef FIFO_BURST_STATS_EN
    .bursts_done    (bursts_done),
    .underrun_cycles(underrun_cycles),
`endif
    .busy           (busy)
  );

  // One clock: observe on the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    logic sf;
    @(negedge clk);
    cyc++;
    sf = s_axis_tvalid && s_axis_tready;
    if (s_axis_tready) s_rdy_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      mq.push_back({m_axis_tlast, m_axis_tdata});
      mcyc.push_back(cyc);
    end
    if (prev_stall && ({m_axis_tlast, m_axis_tdata} !== prev_word)) stab_err++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_word  = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
    if (sf) begin
      s_axis_tdata = s_axis_tdata + 16'd1;
      if (fifo_count != 0) fifo_count = fifo_count - 32'd1;
    end
    if (toggle) m_axis_tready = !m_axis_tready;
  endtask

  // Checks n captured words starting at queue index first: consecutive data, TLAST on the last.
  task automatic check_burst(input string tag, input int first, input int n,
                             input logic [15:0] b);
    logic [15:0] exp_d;
    logic        exp_l;
    for (int i = 0; i < n; i++) begin
      exp_d = b + 16'(i);
      exp_l = (i == n - 1);
      `CHK({tag, "_data"}, mq[first+i][15:0], exp_d)
      `CHK({tag, "_last"}, mq[first+i][16], exp_l)
    end
  endtask

  initial begin
    rst           = 1'b0;
    enable        = 1'b0;
    burst_len     = '0;
    fifo_count    = '0;
    s_axis_tdata  = 16'h1000;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #2;
    `CHK("rst_s_tready", s_axis_tready, 1'b0)
    `CHK("rst_m_tvalid", m_axis_tvalid, 1'b0)
    `CHK("rst_m_tlast", m_axis_tlast, 1'b0)
    `CHK("rst_m_tdata", m_axis_tdata, 16'h0000)
    `CHK("rst_busy", busy, 1'b0)
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: threshold not met, then met exactly.
    enable        = 1'b1;
    burst_len     = 16'd4;
    fifo_count    = 32'd3;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    s_rdy_cnt     = 0;
    repeat (10) tick();
    `CHK("t1_no_ready", s_rdy_cnt, 0)
    `CHK("t1_idle_busy", busy, 1'b0)
    fifo_count = 32'd4;
    mq.delete();
    mcyc.delete();
    base = s_axis_tdata;
    tick();
    `CHK("t1_start_ready", s_axis_tready, 1'b1)
    `CHK("t1_start_busy", busy, 1'b1)
    tick();
    `CHK("t1_latency_valid", m_axis_tvalid, 1'b1)
    `CHK("t1_latency_data", m_axis_tdata, base)
    repeat (12) tick();
    `CHK("t1_count", mq.size(), 4)
    check_burst("t1", 0, 4, base);
    `CHK("t1_fifo_drained", fifo_count, 32'd0)
    `CHK("t1_end_busy", busy, 1'b0)

    // 2: two back-to-back bursts of 8 with both sides always ready.
    burst_len  = 16'd8;
    fifo_count = 32'd16;
    mq.delete();
    mcyc.delete();
    base = s_axis_tdata;
    repeat (30) tick();
    `CHK("t2_count", mq.size(), 16)
    check_burst("t2a", 0, 8, base);
    check_burst("t2b", 8, 8, base + 16'd8);
    `CHK("t2_consecutive", mcyc[7] - mcyc[0], 7)
    `CHK("t2_gap", (mcyc[8] - mcyc[7]) >= 2, 1'b1)

    // 3: downstream ready toggling; nothing lost, duplicated or changed while stalled.
    burst_len  = 16'd5;
    fifo_count = 32'd5;
    toggle     = 1'b1;
    stab_err   = 0;
    mq.delete();
    mcyc.delete();
    base = s_axis_tdata;
    repeat (30) tick();
    toggle        = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    `CHK("t3_count", mq.size(), 5)
    check_burst("t3", 0, 5, base);
    `CHK("t3_stable", stab_err, 0)

    // 4: burst_len of zero never starts.
    burst_len  = 16'd0;
    fifo_count = 32'd100;
    s_rdy_cnt  = 0;
    mq.delete();
    repeat (10) tick();
    `CHK("t4_no_ready", s_rdy_cnt, 0)
    `CHK("t4_busy", busy, 1'b0)
    `CHK("t4_count", mq.size(), 0)

    // 5: asynchronous reset after two of six words, then a complete burst.
    burst_len  = 16'd6;
    fifo_count = 32'd6;
    mq.delete();
    for (int k = 0; k < 20 && mq.size() < 2; k++) tick();
    `CHK("t5_partial", mq.size(), 2)
    rst = 1'b0;
    #1;
    `CHK("t5_rst_valid", m_axis_tvalid, 1'b0)
    `CHK("t5_rst_ready", s_axis_tready, 1'b0)
    `CHK("t5_rst_busy", busy, 1'b0)
    tick();
    tick();
    rst        = 1'b1;
    fifo_count = 32'd6;
    mq.delete();
    base = s_axis_tdata;
    repeat (25) tick();
    `CHK("t5_count", mq.size(), 6)
    check_burst("t5", 0, 6, base);

`ifdef FIFO_BURST_STATS_EN
    // 6: three bursts of 4, data withheld for two cycles at the start of the first.
    rst = 1'b0;
    tick();
    rst           = 1'b1;
    burst_len     = 16'd4;
    fifo_count    = 32'd12;
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    tick();
    s_axis_tvalid = 1'b1;
    repeat (40) tick();
    `CHK("t6_bursts_done", bursts_done, 32'd3)
    `CHK("t6_underrun", underrun_cycles, 32'd2)
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
